// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants, layer geometry and maxpool FSM state encoding.
package cnn_pkg;

    localparam int DATA_W = 16;

    localparam int P1_IN_W = 24;
    localparam int P1_CH   = 6;
    localparam int P2_IN_W = 8;
    localparam int P2_CH   = 16;

    typedef logic [2:0] mp_state_t;

    localparam mp_state_t S_IDLE = 3'd0;
    localparam mp_state_t S_A0   = 3'd1;
    localparam mp_state_t S_A1   = 3'd2;
    localparam mp_state_t S_A2   = 3'd3;
    localparam mp_state_t S_A3   = 3'd4;
    localparam mp_state_t S_CAP  = 3'd5;
    localparam mp_state_t S_WR   = 3'd6;
    localparam mp_state_t S_DONE = 3'd7;

    function automatic int cnt_w(int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnn_maxpool2x2_if.sv
// cnn_maxpool2x2_if: buffer read/write bus plus controller clear/done levels.
interface cnn_maxpool2x2_if #(
    parameter int DATA_W = 16,
    parameter int RD_AW  = 12,
    parameter int WR_AW  = 10
);
    logic              rd_clear;
    logic              wr_clear;
    logic [RD_AW-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [WR_AW-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_done;
    logic              wr_done;

    modport master (
        input  rd_clear, wr_clear, rd_data,
        output rd_addr, wr_en, wr_addr, wr_data, rd_done, wr_done
    );

    modport slave (
        output rd_clear, wr_clear, rd_data,
        input  rd_addr, wr_en, wr_addr, wr_data, rd_done, wr_done
    );
endinterface

// File: rtl/cnn_maxpool2x2_addr_gen.sv
// maxpool_addr_gen: window counters (ocol fastest, then orow, then ch) and tap/output addresses.
module maxpool_addr_gen #(
    parameter int IN_W     = 24,
    parameter int IN_H     = 24,
    parameter int CHANNELS = 6,
    parameter int RD_AW    = 12,
    parameter int WR_AW    = 10
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             advance,
    output logic             last,
    output logic [RD_AW-1:0] tap_addr [4],
    output logic [WR_AW-1:0] out_addr
);
    import cnn_pkg::*;

    localparam int OW    = IN_W / 2;
    localparam int OH    = IN_H / 2;
    localparam int CW_C  = cnt_w(OW);
    localparam int CW_R  = cnt_w(OH);
    localparam int CW_CH = cnt_w(CHANNELS);

    logic [CW_C-1:0]  ocol;
    logic [CW_R-1:0]  orow;
    logic [CW_CH-1:0] ch;
    logic             col_end, row_end, ch_end;
    logic [31:0]      base;

    assign col_end = ocol == CW_C'(OW - 1);
    assign row_end = orow == CW_R'(OH - 1);
    assign ch_end  = ch == CW_CH'(CHANNELS - 1);
    assign last    = col_end && row_end && ch_end;

    assign base        = 32'(ch) * 32'(IN_W * IN_H) + 32'(orow) * 32'(2 * IN_W) + 32'(ocol) * 32'd2;
    assign tap_addr[0] = RD_AW'(base);
    assign tap_addr[1] = RD_AW'(base + 32'd1);
    assign tap_addr[2] = RD_AW'(base + 32'(IN_W));
    assign tap_addr[3] = RD_AW'(base + 32'(IN_W) + 32'd1);
    assign out_addr    = WR_AW'(32'(ch) * 32'(OW * OH) + 32'(orow) * 32'(OW) + 32'(ocol));

    // step to the next window, wrapping ocol, then orow, then ch
    always_ff @(posedge clk) begin
        if (clear) begin
            ocol <= '0;
            orow <= '0;
            ch   <= '0;
        end else if (advance) begin
            ocol <= col_end ? '0 : ocol + 1'b1;
            if (col_end) orow <= row_end ? '0 : orow + 1'b1;
            if (col_end && row_end) ch <= ch_end ? '0 : ch + 1'b1;
        end
    end

endmodule

// File: rtl/cnn_maxpool2x2.sv
// cnn_maxpool2x2: 2x2 stride-2 max-pool engine, 6 cycles per output, no backpressure.
// Define MAXPOOL_RELU_EN to clamp negative pooled values to zero on write.
module cnn_maxpool2x2 #(
    parameter int DATA_W   = 16,
    parameter int IN_W     = 24,
    parameter int IN_H     = 24,
    parameter int CHANNELS = 6,
    parameter int RD_AW    = 12,
    parameter int WR_AW    = 10
) (
    input logic              clk,
    input logic              reset,
    cnn_maxpool2x2_if.master bus
);
    import cnn_pkg::*;

    if (IN_W % 2 != 0 || IN_H % 2 != 0) begin : g_odd_geom
        $error("cnn_maxpool2x2: IN_W and IN_H must be even");
    end
    if ((64'd1 << RD_AW) < 64'(IN_W * IN_H * CHANNELS)) begin : g_rd_aw
        $error("cnn_maxpool2x2: RD_AW too small for input map");
    end
    if ((64'd1 << WR_AW) < 64'((IN_W / 2) * (IN_H / 2) * CHANNELS)) begin : g_wr_aw
        $error("cnn_maxpool2x2: WR_AW too small for output map");
    end

    logic                     clr, last, in_tap;
    mp_state_t                state, state_nx;
    logic [RD_AW-1:0]         tap_addr [4];
    logic [RD_AW-1:0]         rd_addr_q;
    logic [WR_AW-1:0]         out_addr, wr_addr_q;
    logic signed [DATA_W-1:0] sample, max_q, max_upd, pooled, wr_data_q;
    logic                     wr_en_q, rd_done_q, wr_done_q;

    // any clear source restarts the whole engine; there is no partial resume
    assign clr     = reset | bus.rd_clear | bus.wr_clear;
    assign sample  = $signed(bus.rd_data);
    assign max_upd = (sample > max_q) ? sample : max_q;
`ifdef MAXPOOL_RELU_EN
    assign pooled  = max_upd[DATA_W-1] ? '0 : max_upd;
`else
    assign pooled  = max_upd;
`endif

    assign in_tap      = (state >= S_A0) && (state <= S_A3);
    assign bus.rd_addr = in_tap ? tap_addr[2'(state - S_A0)] : rd_addr_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.rd_done = rd_done_q;
    assign bus.wr_done = wr_done_q;

    maxpool_addr_gen #(
        .IN_W     (IN_W),
        .IN_H     (IN_H),
        .CHANNELS (CHANNELS),
        .RD_AW    (RD_AW),
        .WR_AW    (WR_AW)
    ) u_addr_gen (
        .clk      (clk),
        .clear    (clr),
        .advance  (state == S_WR),
        .last     (last),
        .tap_addr (tap_addr),
        .out_addr (out_addr)
    );

    // fixed six-state window sequence; IDLE is only left while no clear is active
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = S_A0;
            S_A0:    state_nx = S_A1;
            S_A1:    state_nx = S_A2;
            S_A2:    state_nx = S_A3;
            S_A3:    state_nx = S_CAP;
            S_CAP:   state_nx = S_WR;
            S_WR:    state_nx = last ? S_DONE : S_A0;
            default: state_nx = S_DONE;
        endcase
    end

    // state register and read-address hold between tap phases
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_IDLE;
            rd_addr_q <= '0;
        end else begin
            state     <= state_nx;
            rd_addr_q <= bus.rd_addr;
        end
    end

    // running max over the taps (data lags address by one cycle), write strobe and done flags
    always_ff @(posedge clk) begin
        if (clr) begin
            max_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            if (state == S_A1) max_q <= sample;
            else if (state == S_A2 || state == S_A3 || state == S_CAP) max_q <= max_upd;
            wr_en_q <= state == S_CAP;
            if (state == S_CAP) begin
                wr_addr_q <= out_addr;
                wr_data_q <= pooled;
            end
            if (state == S_CAP && last) rd_done_q <= 1'b1;
            if (state == S_WR && last) wr_done_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cnn_maxpool2x2.sv
// tb_cnn_maxpool2x2: randomized bench for the 2x2 max-pool engine against a windowed-max reference.
module tb_cnn_maxpool2x2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cnn_maxpool2x2_if #(.DATA_W(16), .RD_AW(4),  .WR_AW(2)) bus_a ();
    cnn_maxpool2x2_if #(.DATA_W(16), .RD_AW(10), .WR_AW(8)) bus_b ();

    cnn_maxpool2x2 #(.DATA_W(16), .IN_W(4), .IN_H(4), .CHANNELS(1), .RD_AW(4), .WR_AW(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    cnn_maxpool2x2 #(.DATA_W(16), .IN_W(8), .IN_H(8), .CHANNELS(16), .RD_AW(10), .WR_AW(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

`ifdef MAXPOOL_RELU_EN
    localparam int EXP_NEG0 = 0;
    localparam int EXP_NEG1 = 0;
`else
    localparam int EXP_NEG0 = -3;
    localparam int EXP_NEG1 = -1;
`endif

    logic signed [15:0] mem_a [16];
    logic signed [15:0] mem_b [1024];
    int oa_addr[$], oa_data[$], ob_addr[$], ob_data[$];
    int n_chk = 0;
    int n_pass = 0;

    always @(posedge clk) bus_a.rd_data <= mem_a[bus_a.rd_addr];
    always @(posedge clk) bus_b.rd_data <= mem_b[bus_b.rd_addr];

    always @(negedge clk) begin
        if (bus_a.wr_en) begin
            oa_addr.push_back(int'(bus_a.wr_addr));
            oa_data.push_back(int'($signed(bus_a.wr_data)));
        end
        if (bus_b.wr_en) begin
            ob_addr.push_back(int'(bus_b.wr_addr));
            ob_data.push_back(int'($signed(bus_b.wr_data)));
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // pooled value of output index o: max of its 2x2 window, optionally ReLU-clamped
    function automatic int ref_val(input bit b, input int w, input int h, input int o);
        int plane, ch, rem, base, m, v, idx;
        plane = (w / 2) * (h / 2);
        ch    = o / plane;
        rem   = o % plane;
        base  = ch * w * h + 2 * (rem / (w / 2)) * w + 2 * (rem % (w / 2));
        m     = -100000;
        for (int t = 0; t < 4; t++) begin
            idx = base + (t / 2) * w + (t % 2);
            v   = b ? int'(mem_b[idx]) : int'(mem_a[idx]);
            if (v > m) m = v;
        end
`ifdef MAXPOOL_RELU_EN
        if (m < 0) m = 0;
`endif
        return m;
    endfunction

    task automatic check_writes(input bit b, input int w, input int h, input int n, input string tag);
        int na;
        na = b ? ob_addr.size() : oa_addr.size();
        check({tag, " write count"}, na, n);
        for (int i = 0; i < na && i < n; i++) begin
            check({tag, " wr_addr"}, b ? ob_addr[i] : oa_addr[i], i);
            check({tag, " wr_data"}, b ? ob_data[i] : oa_data[i], ref_val(b, w, h, i));
        end
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, " rd_addr"}, int'(bus_a.rd_addr), 0);
        check({tag, " wr_en"},   int'(bus_a.wr_en), 0);
        check({tag, " wr_addr"}, int'(bus_a.wr_addr), 0);
        check({tag, " wr_data"}, int'(bus_a.wr_data), 0);
        check({tag, " rd_done"}, int'(bus_a.rd_done), 0);
        check({tag, " wr_done"}, int'(bus_a.wr_done), 0);
    endtask

    // call at a negedge: releases every clear, then counts edges until wr_done (bounded)
    task automatic run_a(output int rd_at, output int wr_at, output int first_rd);
        rd_at = -1;
        wr_at = -1;
        first_rd = -1;
        reset = 1'b0;
        bus_a.rd_clear = 1'b0;
        bus_a.wr_clear = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) first_rd = int'(bus_a.rd_addr);
            if (rd_at < 0 && bus_a.rd_done) rd_at = k;
            if (bus_a.wr_done) begin
                wr_at = k;
                break;
            end
        end
    endtask

    task automatic clear_a();
        @(negedge clk);
        bus_a.rd_clear = 1'b1;
        bus_a.wr_clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        oa_addr.delete();
        oa_data.delete();
    endtask

    initial begin
        int rd_at, wr_at, first_rd, v16;
        int prev_addr[$], prev_data[$];
        bus_a.rd_clear = 1'b1;
        bus_a.wr_clear = 1'b1;
        bus_b.rd_clear = 1'b1;
        bus_b.wr_clear = 1'b1;
        for (int i = 0; i < 16; i++) mem_a[i] = 16'(i);
        for (int i = 0; i < 1024; i++) mem_b[i] = 16'($urandom_range(0, 1998)) - 16'd999;
        repeat (3) @(posedge clk);
        #1;
        check_idle_a("reset");
        check("reset b rd_done", int'(bus_b.rd_done), 0);
        check("reset b wr_done", int'(bus_b.wr_done), 0);
        check("reset b wr_en", int'(bus_b.wr_en), 0);

        // basic 4x4x1 ramp
        @(negedge clk);
        reset = 1'b0;
        oa_addr.delete();
        oa_data.delete();
        run_a(rd_at, wr_at, first_rd);
        check("basic first rd_addr", first_rd, 0);
        check("basic rd_done cycle", rd_at, 24);
        check("basic wr_done cycle", wr_at, 25);
        repeat (4) @(posedge clk);
        #1;
        check("basic done hold rd", int'(bus_a.rd_done), 1);
        check("basic done hold wr", int'(bus_a.wr_done), 1);
        check_writes(0, 4, 4, 4, "basic");
        if (oa_data.size() == 4) begin
            check("basic w0", oa_data[0], 5);
            check("basic w1", oa_data[1], 7);
            check("basic w2", oa_data[2], 13);
            check("basic w3", oa_data[3], 15);
        end else begin
            check("basic pulse count", oa_data.size(), 4);
        end

        // rd_clear alone clears and holds idle, release gives identical traffic
        @(negedge clk);
        bus_a.rd_clear = 1'b1;
        @(posedge clk);
        #1;
        check("clr rd_done", int'(bus_a.rd_done), 0);
        check("clr wr_done", int'(bus_a.wr_done), 0);
        prev_addr = oa_addr;
        prev_data = oa_data;
        oa_addr.delete();
        oa_data.delete();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("clr hold rd_addr", int'(bus_a.rd_addr), 0);
        end
        check("clr hold writes", oa_addr.size(), 0);
        @(negedge clk);
        run_a(rd_at, wr_at, first_rd);
        check("rerun wr_done cycle", wr_at, 25);
        check("rerun write count", oa_addr.size(), prev_addr.size());
        for (int i = 0; i < oa_addr.size() && i < prev_addr.size(); i++) begin
            check("rerun wr_addr", oa_addr[i], prev_addr[i]);
            check("rerun wr_data", oa_data[i], prev_data[i]);
        end

        // signed compare and ties
        clear_a();
        for (int i = 0; i < 16; i++) mem_a[i] = 16'($urandom);
        mem_a[0] = -16'sd3;
        mem_a[1] = -16'sd7;
        mem_a[4] = -16'sd3;
        mem_a[5] = -16'sd100;
        mem_a[2] = -16'sd32768;
        mem_a[3] = -16'sd1;
        mem_a[6] = -16'sd2;
        mem_a[7] = -16'sd32768;
        run_a(rd_at, wr_at, first_rd);
        check("signed wr_done cycle", wr_at, 25);
        check("signed w0", oa_data.size() > 0 ? oa_data[0] : 99999, EXP_NEG0);
        check("signed w1", oa_data.size() > 1 ? oa_data[1] : 99999, EXP_NEG1);
        check_writes(0, 4, 4, 4, "signed");

        // random windows, with many small values to provoke ties
        for (int r = 0; r < 4; r++) begin
            clear_a();
            for (int i = 0; i < 16; i++)
                mem_a[i] = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 6)) - 16'd3;
            run_a(rd_at, wr_at, first_rd);
            check("rand wr_done cycle", wr_at, 25);
            check_writes(0, 4, 4, 4, "rand");
        end

        // synchronous reset mid-run
        clear_a();
        for (int i = 0; i < 16; i++) mem_a[i] = 16'($urandom_range(0, 200)) - 16'd100;
        bus_a.rd_clear = 1'b0;
        bus_a.wr_clear = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_idle_a("midrst");
        oa_addr.delete();
        oa_data.delete();
        @(negedge clk);
        run_a(rd_at, wr_at, first_rd);
        check("midrst first rd_addr", first_rd, 0);
        check("midrst wr_done cycle", wr_at, 25);
        check_writes(0, 4, 4, 4, "midrst");

        // P2 geometry, 8x8x16
        clear_a();
        mem_b[73] = 16'sd12345;
        ob_addr.delete();
        ob_data.delete();
        bus_b.rd_clear = 1'b0;
        bus_b.wr_clear = 1'b0;
        rd_at = -1;
        wr_at = -1;
        for (int k = 1; k <= 1600; k++) begin
            @(posedge clk);
            #1;
            if (rd_at < 0 && bus_b.rd_done) rd_at = k;
            if (bus_b.wr_done) begin
                wr_at = k;
                break;
            end
        end
        check("p2 rd_done cycle", rd_at, 1536);
        check("p2 wr_done cycle", wr_at, 1537);
        check("p2 last wr_addr", ob_addr.size() > 0 ? ob_addr[ob_addr.size() - 1] : -1, 255);
        v16 = -1;
        foreach (ob_addr[i]) if (ob_addr[i] == 16) v16 = ob_data[i];
        check("p2 out16 from base 64", v16, 12345);
        check_writes(1, 8, 8, 256, "p2");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
